// File: rtl/pll_reset_sequencer_if.sv
// pll_reset_sequencer_if
// Groups the PLL-facing and system-facing signals of the reset sequencer.
//   locked      : PLL lock indication, asynchronous to the reference clock
//   pll_rst     : active-high reset into the PLL
//   sys_rst_n   : active-low system reset released after stable lock
//   retry_count : saturating count of PLL reset retries
//   state       : sequencer state, debug visibility only
// The master modport is the sequencer; the slave modport is the PLL/system side.
interface pll_reset_sequencer_if;
  logic       locked;
  logic       pll_rst;
  logic       sys_rst_n;
  logic [7:0] retry_count;
  logic [1:0] state;

  modport master (
    input  locked,
    output pll_rst,
    output sys_rst_n,
    output retry_count,
    output state
  );

  modport slave (
    output locked,
    input  pll_rst,
    input  sys_rst_n,
    input  retry_count,
    input  state
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Sequences the PLL reset and the system reset from the always-running
// reference clock. The PLL is held in reset for a fixed pulse, then lock is
// awaited (with a timeout that retries the PLL reset), lock must then stay
// stable for a programmable time before the system reset is released. Lock
// loss while running restarts the whole sequence and counts a retry.
// Ports:
//   refclk : reference clock (also feeds the PLL)
//   rst_n  : asynchronous active-low reset
//   bus    : master modport carrying locked in, pll_rst / sys_rst_n /
//            retry_count / state out
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int SYNC_STAGES         = 2
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  pll_reset_sequencer_if.master bus
);

  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC);

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_PLL_RESET = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [7:0]             retry_q, retry_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   pll_rst_q, pll_rst_d;
  logic                   sys_rst_n_q, sys_rst_n_d;
  logic                   locked_s;
  logic [7:0]             retry_inc;

  // State register: all flops share the asynchronous reset.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PLL_RESET;
      cnt_q       <= '0;
      retry_q     <= '0;
      sync_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      sync_q      <= sync_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
    end
  end

  // Lock synchronizer: bit 0 samples the asynchronous input.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.locked};
  end

  assign locked_s  = sync_q[SYNC_STAGES-1];
  assign retry_inc = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;

  // Next-state logic, including the shared counter and retry counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    retry_d = retry_q;
    case (state_q)
      ST_PLL_RESET: begin
        if (cnt_q == PLL_RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // Lock takes precedence over a coincident timeout.
        if (locked_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ST_PLL_RESET;
          retry_d = retry_inc;
        end
      end
      ST_STABLE: begin
        // A glitch only restarts the lock wait; it is not a retry.
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!locked_s) begin
          state_d = ST_PLL_RESET;
          retry_d = retry_inc;
        end
      end
      default: begin
        state_d = ST_PLL_RESET;
      end
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Output decode from the next state so the registered outputs change on
  // the same edge as the state itself.
  always_comb begin
    pll_rst_d   = (state_d == ST_PLL_RESET);
    sys_rst_n_d = (state_d == ST_RUN);
  end

  assign bus.pll_rst     = pll_rst_q;
  assign bus.sys_rst_n   = sys_rst_n_q;
  assign bus.retry_count = retry_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
// Scoreboard bench for pll_reset_sequencer with PLL_RST_CYCLES=4,
// LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, SYNC_STAGES=2.
// Expected output snapshots are queued against an edge number (edges counted
// from rst_n release) when stimulus is driven and compared on the following
// falling clock edge.
module tb_pll_reset_sequencer;

  logic refclk = 1'b0;
  logic rst_n  = 1'b1;
  int   cyc    = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  pll_reset_sequencer_if bus ();

  pll_reset_sequencer #(
    .PLL_RST_CYCLES     (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32),
    .SYNC_STAGES        (2)
  ) dut (
    .refclk(refclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 refclk = ~refclk;

  // Edge counter: edge 1 is the first rising edge after rst_n releases.
  always @(posedge refclk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    string      tag;
    int         cyc;
    logic [1:0] st;
    logic       pll;
    logic       sys;
    logic [7:0] rc;
  } exp_t;

  exp_t sb[$];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int c, input logic [1:0] st,
                      input logic pll, input logic sys, input logic [7:0] rc);
    exp_t e;
    e.tag = tag; e.cyc = c; e.st = st; e.pll = pll; e.sys = sys; e.rc = rc;
    sb.push_back(e);
  endtask

  // Compare queued snapshots once their edge has been reached.
  always @(negedge refclk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc != cyc) begin
        check_value({e.tag, ".edge"}, cyc, e.cyc);
      end else begin
        $display("[edge %0d] %s: state=%0d pll_rst=%0b sys_rst_n=%0b retry=%0d",
                 cyc, e.tag, bus.state, bus.pll_rst, bus.sys_rst_n, bus.retry_count);
        check_value({e.tag, ".state"},     bus.state,       e.st);
        check_value({e.tag, ".pll_rst"},   bus.pll_rst,     e.pll);
        check_value({e.tag, ".sys_rst_n"}, bus.sys_rst_n,   e.sys);
        check_value({e.tag, ".retry"},     bus.retry_count, e.rc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge refclk);
    #2;
  endtask

  task automatic wait_cyc(input int target);
    int n = 0;
    while (cyc < target && n < 20000) begin
      @(posedge refclk);
      #2;
      n++;
    end
  endtask

  // Wait for the scoreboard to empty, bounded; leftovers count as a failure.
  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(negedge refclk);
      #1;
      n++;
    end
    check_value({tag, ".drain"}, sb.size(), 0);
    sb.delete();
    @(posedge refclk);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    $display("[async] %s: state=%0d pll_rst=%0b sys_rst_n=%0b retry=%0d",
             tag, bus.state, bus.pll_rst, bus.sys_rst_n, bus.retry_count);
    check_value({tag, ".state"},     bus.state,       2'd0);
    check_value({tag, ".pll_rst"},   bus.pll_rst,     1'b1);
    check_value({tag, ".sys_rst_n"}, bus.sys_rst_n,   1'b0);
    check_value({tag, ".retry"},     bus.retry_count, 8'd0);
  endtask

  // Hold reset for a few clocks with locked low, then release just after an edge.
  task automatic do_reset();
    bus.locked = 1'b0;
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus.locked = 1'b0;
    #1;

    // Reset held, then release.
    rst_n = 1'b0;
    step(3);
    check_reset_outputs("reset_held");
    rst_n = 1'b1;
    push("rel_e1", 1, 2'd0, 1'b1, 1'b0, 8'd0);
    push("rel_e3", 3, 2'd0, 1'b1, 1'b0, 8'd0);
    push("rel_e4", 4, 2'd1, 1'b0, 1'b0, 8'd0);

    // Clean lock: locked rises before edge 7, release at edge 17.
    wait_cyc(6);
    bus.locked = 1'b1;
    k = cyc + 1;
    push("lock_stable", k + 9,  2'd2, 1'b0, 1'b0, 8'd0);
    push("lock_run",    k + 10, 2'd3, 1'b0, 1'b1, 8'd0);
    drain("clean_lock", 100);

    // Lock loss in RUN.
    bus.locked = 1'b0;
    k = cyc + 1;
    push("loss_k1", k + 1, 2'd3, 1'b0, 1'b1, 8'd0);
    push("loss_k2", k + 2, 2'd0, 1'b1, 1'b0, 8'd1);
    push("loss_k5", k + 5, 2'd0, 1'b1, 1'b0, 8'd1);
    push("loss_k6", k + 6, 2'd1, 1'b0, 1'b0, 8'd1);
    drain("lock_loss", 100);

    // One-cycle glitch in STABLE, re-raised before edge m = k+6.
    bus.locked = 1'b1;
    k = cyc + 1;
    push("glitch_stable", k + 2,  2'd2, 1'b0, 1'b0, 8'd1);
    push("glitch_hold",   k + 6,  2'd2, 1'b0, 1'b0, 8'd1);
    push("glitch_wait",   k + 7,  2'd1, 1'b0, 1'b0, 8'd1);
    push("glitch_relock", k + 8,  2'd2, 1'b0, 1'b0, 8'd1);
    push("glitch_m9",     k + 15, 2'd2, 1'b0, 1'b0, 8'd1);
    push("glitch_m10",    k + 16, 2'd3, 1'b0, 1'b1, 8'd1);
    step(5);
    bus.locked = 1'b0;
    step(1);
    bus.locked = 1'b1;
    drain("glitch", 100);

    // Second lock loss, quick relock, then reset asserted mid-STABLE.
    bus.locked = 1'b0;
    k = cyc + 1;
    push("loss2_k2", k + 2, 2'd0, 1'b1, 1'b0, 8'd2);
    push("loss2_k6", k + 6, 2'd1, 1'b0, 1'b0, 8'd2);
    push("loss2_k7", k + 7, 2'd2, 1'b0, 1'b0, 8'd2);
    step(1);
    bus.locked = 1'b1;
    drain("relock", 100);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_stable");

    // Timeout retries, then lock coinciding with the second timeout edge.
    bus.locked = 1'b0;
    step(3);
    rst_n = 1'b1;
    push("to_e4",  4,  2'd1, 1'b0, 1'b0, 8'd0);
    push("to_e35", 35, 2'd1, 1'b0, 1'b0, 8'd0);
    push("to_e36", 36, 2'd0, 1'b1, 1'b0, 8'd1);
    push("to_e39", 39, 2'd0, 1'b1, 1'b0, 8'd1);
    push("to_e40", 40, 2'd1, 1'b0, 1'b0, 8'd1);
    push("to_e71", 71, 2'd1, 1'b0, 1'b0, 8'd1);
    push("lock_on_timeout", 72, 2'd2, 1'b0, 1'b0, 8'd1);
    push("lock_on_timeout_run", 80, 2'd3, 1'b0, 1'b1, 8'd1);
    wait_cyc(69);
    bus.locked = 1'b1;
    drain("timeout", 200);

    // Saturation: hold locked low for 300 timeouts.
    do_reset();
    push("sat_e9179",  9179,  2'd1, 1'b0, 1'b0, 8'd254);
    push("sat_e9180",  9180,  2'd0, 1'b1, 1'b0, 8'd255);
    push("sat_e9216",  9216,  2'd0, 1'b1, 1'b0, 8'd255);
    push("sat_e10800", 10800, 2'd0, 1'b1, 1'b0, 8'd255);
    drain("saturation", 11000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
